// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the execute/memory stages, the issue logic and the
// register-file write-port arbiter.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 64
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            mdu_valid;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic            mdu_ready;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [31:0]     busy;
  logic            alu_stall;
  logic            err;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output iss_valid, iss_rd,
    input  lsu_ready, mdu_ready, busy, alu_stall, err,
    input  wb_we, wb_rd, wb_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  iss_valid, iss_rd,
    output lsu_ready, mdu_ready, busy, alu_stall, err,
    output wb_we, wb_rd, wb_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port among ALU, LSU and MDU and
// tracks a per-register pending-write scoreboard for the hazard unit.
module regfile_wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    PREF_LSU = 1'b0,
    PREF_MDU = 1'b1
  } rr_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  rr_t             rr_reg, rr_next;
  logic [3:0]      starve_reg, starve_next;
  logic            stall_reg, stall_next;
  logic            err_reg, err_next;
  logic [31:0]     busy_reg, busy_next;
  logic            wb_we_reg, wb_we_next;
  logic [4:0]      wb_rd_reg, wb_rd_next;
  logic [XLEN-1:0] wb_data_reg, wb_data_next;

  logic            grant_lsu, grant_mdu, grant_any, iss_set;
  logic [4:0]      g_rd;
  logic [XLEN-1:0] g_data;
  logic [31:0]     clr_vec, set_vec;

  always_comb begin
    grant_lsu = 1'b0;
    grant_mdu = 1'b0;
    g_rd      = bus.alu_rd;
    g_data    = bus.alu_data;
    if (!bus.alu_valid) begin
      grant_lsu = bus.lsu_valid && (rr_reg == PREF_LSU || !bus.mdu_valid);
      grant_mdu = bus.mdu_valid && (rr_reg == PREF_MDU || !bus.lsu_valid);
      if (grant_mdu) begin
        g_rd   = bus.mdu_rd;
        g_data = bus.mdu_data;
      end else begin
        g_rd   = bus.lsu_rd;
        g_data = bus.lsu_data;
      end
    end
    grant_any = bus.alu_valid || grant_lsu || grant_mdu;
    iss_set   = bus.iss_valid && (bus.iss_rd != 5'd0);
  end

  // x0 is never tracked; an issue to the register being retired wins.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign clr_vec[gi]   = 1'b0;
        assign set_vec[gi]   = 1'b0;
        assign busy_next[gi] = 1'b0;
      end else begin : g_xn
        assign clr_vec[gi]   = grant_any && (g_rd == 5'(gi));
        assign set_vec[gi]   = iss_set && (bus.iss_rd == 5'(gi));
        assign busy_next[gi] = set_vec[gi] | (busy_reg[gi] & ~clr_vec[gi]);
      end
    end
  endgenerate

  always_comb begin
    err_next = err_reg
             | (bus.alu_valid & stall_reg)
             | (iss_set & busy_reg[bus.iss_rd] & ~clr_vec[bus.iss_rd])
             | (grant_any & (g_rd != 5'd0) & ~busy_reg[g_rd]);

    starve_next = starve_reg;
    if (grant_lsu || grant_mdu || !(bus.lsu_valid || bus.mdu_valid))
      starve_next = 4'd0;
    else if (starve_reg != 4'd15)
      starve_next = starve_reg + 4'd1;
    stall_next = (starve_next >= LIMIT);

    rr_next = rr_reg;
    if (grant_lsu)
      rr_next = PREF_MDU;
    else if (grant_mdu)
      rr_next = PREF_LSU;

    wb_we_next   = 1'b0;
    wb_rd_next   = wb_rd_reg;
    wb_data_next = wb_data_reg;
    if (grant_any) begin
      wb_we_next   = (g_rd != 5'd0);
      wb_rd_next   = g_rd;
      wb_data_next = g_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_reg      <= PREF_LSU;
      starve_reg  <= 4'd0;
      stall_reg   <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= '0;
      wb_we_reg   <= 1'b0;
      wb_rd_reg   <= 5'd0;
      wb_data_reg <= '0;
    end else begin
      rr_reg      <= rr_next;
      starve_reg  <= starve_next;
      stall_reg   <= stall_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
      wb_we_reg   <= wb_we_next;
      wb_rd_reg   <= wb_rd_next;
      wb_data_reg <= wb_data_next;
    end
  end

  assign bus.lsu_ready = grant_lsu;
  assign bus.mdu_ready = grant_mdu;
  assign bus.busy      = busy_reg;
  assign bus.alu_stall = stall_reg;
  assign bus.err       = err_reg;
  assign bus.wb_we     = wb_we_reg;
  assign bus.wb_rd     = wb_rd_reg;
  assign bus.wb_data   = wb_data_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter: a reference model
// predicts each cycle's response into a queue that a monitor checks.
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 64;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int        gnt;      // 0 none, 1 ALU, 2 LSU, 3 MDU
    bit        lsu_rdy;
    bit        mdu_rdy;
    bit        we;
    bit [4:0]  rd;
    bit [63:0] data;
    bit [31:0] busy;
    bit        stall;
    bit        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_it;
  int checks = 0;
  int errors = 0;
  int txn    = 0;

  // reference model state
  bit [31:0] m_busy;
  int        m_cnt;
  bit        m_stall, m_err, m_pref_mdu, m_we;
  bit [4:0]  m_rd;
  bit [63:0] m_data;
  // held requests and per-cycle stimulus
  bit        lsu_p, mdu_p;
  bit [4:0]  lsu_prd, mdu_prd;
  bit [63:0] lsu_pd, mdu_pd;
  bit        a_v, i_v;
  bit [4:0]  a_rd, i_rd;
  bit [63:0] a_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic bit [4:0] pick_rd();
    bit [4:0] r;
    if ($urandom_range(3, 0) != 0 && m_busy != 0) begin
      for (int t = 0; t < 64; t++) begin
        r = 5'($urandom_range(31, 0));
        if (m_busy[r]) return r;
      end
    end
    return 5'($urandom_range(31, 0));
  endfunction

  task automatic req_lsu(input bit [4:0] rd, input bit [63:0] d);
    if (!lsu_p) begin lsu_p = 1; lsu_prd = rd; lsu_pd = d; end
  endtask

  task automatic req_mdu(input bit [4:0] rd, input bit [63:0] d);
    if (!mdu_p) begin mdu_p = 1; mdu_prd = rd; mdu_pd = d; end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cnt = 0; m_stall = 0; m_err = 0; m_pref_mdu = 0;
    m_we = 0; m_rd = 0; m_data = 0;
  endtask

  // Drive this cycle's inputs and predict what the next edge produces.
  task automatic step_body();
    int        g;
    bit [4:0]  grd;
    bit [63:0] gd;
    exp_t      e;
    bus.alu_valid = a_v;   bus.alu_rd = a_rd;   bus.alu_data = a_d;
    bus.lsu_valid = lsu_p; bus.lsu_rd = lsu_prd; bus.lsu_data = lsu_pd;
    bus.mdu_valid = mdu_p; bus.mdu_rd = mdu_prd; bus.mdu_data = mdu_pd;
    bus.iss_valid = i_v;   bus.iss_rd = i_rd;

    g = 0;
    if (a_v) g = 1;
    else if (lsu_p && mdu_p) g = m_pref_mdu ? 3 : 2;
    else if (lsu_p) g = 2;
    else if (mdu_p) g = 3;
    grd = (g == 1) ? a_rd : (g == 2) ? lsu_prd : mdu_prd;
    gd  = (g == 1) ? a_d  : (g == 2) ? lsu_pd  : mdu_pd;

    if (a_v && m_stall) m_err = 1;
    if (i_v && i_rd != 0 && m_busy[i_rd] && !(g != 0 && grd == i_rd)) m_err = 1;
    if (g != 0 && grd != 0 && !m_busy[grd]) m_err = 1;

    if (g != 0) m_busy[grd] = 0;
    if (i_v && i_rd != 0) m_busy[i_rd] = 1;

    if (g != 0) begin m_we = (grd != 0); m_rd = grd; m_data = gd; end
    else m_we = 0;

    if (g >= 2 || !(lsu_p || mdu_p)) m_cnt = 0;
    else if (m_cnt < 15) m_cnt++;
    m_stall = (m_cnt >= LIMIT);

    e.lsu_rdy = (g == 2);
    e.mdu_rdy = (g == 3);
    if (g == 2) begin m_pref_mdu = 1; lsu_p = 0; end
    if (g == 3) begin m_pref_mdu = 0; mdu_p = 0; end

    e.gnt = g; e.we = m_we; e.rd = m_rd; e.data = m_data;
    e.busy = m_busy; e.stall = m_stall; e.err = m_err;
    q.push_back(e);
    a_v = 0; i_v = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    step_body();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    bus.alu_valid = 1'b0;
    bus.iss_valid = 1'b0;
    #1;
    chk("rst_wb_we",     bus.wb_we,     0);
    chk("rst_wb_rd",     bus.wb_rd,     0);
    chk("rst_wb_data",   bus.wb_data,   0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_alu_stall", bus.alu_stall, 0);
    chk("rst_err",       bus.err,       0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step_body();
  endtask

  // Monitor: ready is checked mid-cycle, registered outputs after the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mon_it = q.pop_front();
        chk("lsu_ready", bus.lsu_ready, mon_it.lsu_rdy);
        chk("mdu_ready", bus.mdu_ready, mon_it.mdu_rdy);
        @(posedge clk); #2;
        chk("wb_we",     bus.wb_we,     mon_it.we);
        chk("wb_rd",     bus.wb_rd,     mon_it.rd);
        chk("wb_data",   bus.wb_data,   mon_it.data);
        chk("busy",      bus.busy,      mon_it.busy);
        chk("alu_stall", bus.alu_stall, mon_it.stall);
        chk("err",       bus.err,       mon_it.err);
        if (mon_it.gnt != 0) begin
          txn++;
          $display("txn %0d: src=%s rd=%0d data=%h we=%0b busy=%h err=%0b",
                   txn, (mon_it.gnt == 1) ? "ALU" : (mon_it.gnt == 2) ? "LSU" : "MDU",
                   mon_it.rd, mon_it.data, mon_it.we, mon_it.busy, mon_it.err);
        end
      end
    end
  end

  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.mdu_valid = 0; bus.mdu_rd = 0; bus.mdu_data = 0;
    bus.iss_valid = 0; bus.iss_rd = 0;
    lsu_p = 0; mdu_p = 0; lsu_prd = 0; mdu_prd = 0; lsu_pd = 0; mdu_pd = 0;
    a_v = 0; a_rd = 0; a_d = 0; i_v = 0; i_rd = 0;
    model_reset();
    do_reset();

    // ALU write of 0xAAAA to x5
    i_v = 1; i_rd = 5; step();
    a_v = 1; a_rd = 5; a_d = 64'hAAAA; step();
    step();

    // LSU and MDU contend: LSU first, then MDU
    i_v = 1; i_rd = 3; step();
    i_v = 1; i_rd = 4; step();
    req_lsu(3, 64'h3333); req_mdu(4, 64'h4444); step();
    step();
    step();

    // starvation of the LSU under continuous ALU traffic to x0
    i_v = 1; i_rd = 6; step();
    req_lsu(6, 64'h6666);
    for (int k = 0; k < 20 && !m_stall; k++) begin
      a_v = 1; a_rd = 0; a_d = rnd64(); step();
    end
    step();
    step();

    // scoreboard set/clear, including set winning over clear
    i_v = 1; i_rd = 7; step();
    step(); step();
    req_lsu(7, 64'h7777); step();
    i_v = 1; i_rd = 7; step();
    a_v = 1; a_rd = 7; a_d = 64'h7070; i_v = 1; i_rd = 7; step();
    a_v = 1; a_rd = 7; a_d = 64'h0707; step();

    // MDU write to x0, then a WAW issue sets the sticky error
    req_mdu(0, 64'hDEAD); step();
    step();
    i_v = 1; i_rd = 9; step();
    i_v = 1; i_rd = 9; step();
    step(); step();

    // reset while a write is in flight and an LSU request is held
    for (int r = 8; r <= 12; r++) begin i_v = 1; i_rd = 5'(r); step(); end
    a_v = 1; a_rd = 12; a_d = 64'hC0DE; req_lsu(9, 64'h9999); step();
    do_reset();
    step(); step();

    // randomized traffic, two phases separated by a reset
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 300; n++) begin
        if ($urandom_range(2, 0) == 0 && (!m_stall || $urandom_range(15, 0) == 0)) begin
          a_v = 1; a_rd = pick_rd(); a_d = rnd64();
        end
        if ($urandom_range(2, 0) == 0) req_lsu(pick_rd(), rnd64());
        if ($urandom_range(3, 0) == 0) req_mdu(pick_rd(), rnd64());
        if ($urandom_range(2, 0) == 0) begin
          i_rd = 5'($urandom_range(31, 0));
          if (!m_busy[i_rd] || $urandom_range(7, 0) == 0) i_v = 1;
        end
        step();
      end
      if (ph == 0) do_reset();
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
